// File: rtl/ladybird_config.sv
// Shared ladybird address map and ACLINT register decode helpers.
package ladybird_config;

  localparam logic [31:0] MEMORY_BASEADDR_ACLINT = 32'h0200_0000;
  localparam logic [31:0] ACLINT_MSWI_BASE       = MEMORY_BASEADDR_ACLINT + 32'h0000_0000;
  localparam logic [31:0] ACLINT_MTIMER_BASE     = MEMORY_BASEADDR_ACLINT + 32'h0000_4000;
  localparam logic [31:0] ACLINT_SSWI_BASE       = MEMORY_BASEADDR_ACLINT + 32'h0000_8000;

  // Offsets relative to MEMORY_BASEADDR_ACLINT
  localparam logic [31:0] ACLINT_MSIP_OFS        = 32'h0000_0000;
  localparam logic [31:0] ACLINT_MTIMECMP_LO_OFS = 32'h0000_4000;
  localparam logic [31:0] ACLINT_MTIMECMP_HI_OFS = 32'h0000_4004;
  localparam logic [31:0] ACLINT_SETSSIP_OFS     = 32'h0000_8000;
  localparam logic [31:0] ACLINT_MTIME_LO_OFS    = 32'h0000_BFF8;
  localparam logic [31:0] ACLINT_MTIME_HI_OFS    = 32'h0000_BFFC;

  typedef enum logic [2:0] {
    MSIP,
    MTIMECMP_LO,
    MTIMECMP_HI,
    MTIME_LO,
    MTIME_HI,
    SETSSIP,
    NONE
  } aclint_reg_t;

  function automatic aclint_reg_t aclint_decode(input logic [31:0] ofs);
    aclint_reg_t sel;
    case (ofs)
      ACLINT_MSIP_OFS:        sel = MSIP;
      ACLINT_MTIMECMP_LO_OFS: sel = MTIMECMP_LO;
      ACLINT_MTIMECMP_HI_OFS: sel = MTIMECMP_HI;
      ACLINT_SETSSIP_OFS:     sel = SETSSIP;
      ACLINT_MTIME_LO_OFS:    sel = MTIME_LO;
      ACLINT_MTIME_HI_OFS:    sel = MTIME_HI;
      default:                sel = NONE;
    endcase
    return sel;
  endfunction

  // Replace only the strobed bytes of a 32-bit word
  function automatic logic [31:0] merge_bytes(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[8*b +: 8] = strb[b] ? new_val[8*b +: 8] : old_val[8*b +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/ladybird_aclint_prescaler.sv
// Divides the core clock into a one-cycle mtime tick every TICK_DIV cycles.
module ladybird_aclint_prescaler #(
  parameter int unsigned TICK_DIV = 10
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int unsigned CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] count;

  // With TICK_DIV=1 the count stays at 0 and tick is permanently high
  assign tick = (count == LAST);

  // Free-running 0..TICK_DIV-1 counter
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (tick) begin
      count <= '0;
    end else begin
      count <= count + CW'(1);
    end
  end

endmodule

// File: rtl/ladybird_aclint.sv
// ACLINT slave: MTIMER (mtime/mtimecmp), MSWI (msip) and SSWI (setssip) behind a
// single-outstanding valid/ready request port with a registered response.
module ladybird_aclint
  import ladybird_config::*;
#(
  parameter int unsigned TICK_DIV    = 10,
  parameter logic [63:0] MTIME_RESET = 64'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_valid,
  output logic        i_ready,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wdata,
  input  logic [3:0]  i_wstrb,
  output logic        o_valid,
  input  logic        o_ready,
  output logic [31:0] o_rdata,
  output logic        o_error,
  output logic        mtip,
  output logic        msip,
  output logic        ssip
);

  logic [63:0] mtime;
  logic [63:0] mtimecmp;
  logic        msip_r;
  logic        tick;
  logic        accept;
  logic        misaligned;
  logic        bad;
  logic        wr;
  logic [31:0] offset;
  logic [31:0] rdata;
  aclint_reg_t sel;

  ladybird_aclint_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .tick  (tick)
  );

  assign i_ready    = !o_valid || o_ready;
  assign accept     = i_valid && i_ready;
  assign misaligned = (i_addr[1:0] != 2'b00);
  assign offset     = i_addr - MEMORY_BASEADDR_ACLINT;
  assign sel        = misaligned ? NONE : aclint_decode(offset);
  assign bad        = (sel == NONE);
  assign wr         = accept && (i_wstrb != 4'b0000) && !bad;
  assign msip       = msip_r;

  // Read data mux of the current register values
  always_comb begin
    rdata = 32'h0;
    case (sel)
      MSIP:        rdata = {31'h0, msip_r};
      MTIMECMP_LO: rdata = mtimecmp[31:0];
      MTIMECMP_HI: rdata = mtimecmp[63:32];
      MTIME_LO:    rdata = mtime[31:0];
      MTIME_HI:    rdata = mtime[63:32];
      default:     rdata = 32'h0;
    endcase
  end

  // mtime: a write to either half wins over the tick and suppresses the carry
  always_ff @(posedge clk) begin
    if (reset) begin
      mtime <= MTIME_RESET;
    end else if (wr && sel == MTIME_LO) begin
      mtime[31:0] <= merge_bytes(mtime[31:0], i_wdata, i_wstrb);
    end else if (wr && sel == MTIME_HI) begin
      mtime[63:32] <= merge_bytes(mtime[63:32], i_wdata, i_wstrb);
    end else if (tick) begin
      mtime <= mtime + 64'd1;
    end
  end

  // mtimecmp, msip_r and the one-cycle ssip pulse
  always_ff @(posedge clk) begin
    if (reset) begin
      mtimecmp <= 64'hFFFF_FFFF_FFFF_FFFF;
      msip_r   <= 1'b0;
      ssip     <= 1'b0;
    end else begin
      if (wr && sel == MTIMECMP_LO) begin
        mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], i_wdata, i_wstrb);
      end
      if (wr && sel == MTIMECMP_HI) begin
        mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], i_wdata, i_wstrb);
      end
      if (wr && sel == MSIP && i_wstrb[0]) begin
        msip_r <= i_wdata[0];
      end
      ssip <= wr && (sel == SETSSIP) && i_wstrb[0] && i_wdata[0];
    end
  end

  // Registered timer compare
  always_ff @(posedge clk) begin
    if (reset) begin
      mtip <= 1'b0;
    end else begin
      mtip <= (mtime >= mtimecmp);
    end
  end

  // Response register, held until consumed
  always_ff @(posedge clk) begin
    if (reset) begin
      o_valid <= 1'b0;
      o_rdata <= 32'h0;
      o_error <= 1'b0;
    end else if (accept) begin
      o_valid <= 1'b1;
      o_rdata <= (i_wstrb == 4'b0000) ? rdata : 32'h0;
      o_error <= bad;
    end else if (o_ready) begin
      o_valid <= 1'b0;
    end
  end

endmodule
